// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, legal prescale
// constants and small helper functions used by the core and its sampler.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      CHECK
   } rx_state_e;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   // Anything other than 16 or 32 falls back to 8 clocks per bit.
   function automatic logic [5:0] legal_prescale(input logic [5:0] p);
      if (p == PRESCALE_16 || p == PRESCALE_32) begin
         return p;
      end
      return PRESCALE_8;
   endfunction

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter plus three-point majority vote around the bit centre.
// bit_end_o marks the last clock of a bit period; bit_o is the voted value then.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rest,
   input  logic       en_i,
   input  logic       rx_i,
   input  logic [5:0] presc_i,
   output logic       bit_end_o,
   output logic       bit_o
);

   logic [5:0] cnt_q, cnt_d;
   logic [2:0] smp_q, smp_d;
   logic [5:0] half;

   assign half      = presc_i >> 1;
   assign bit_end_o = en_i && (cnt_q == presc_i - 6'd1);
   assign bit_o     = maj3(smp_q);

   always_comb begin
      cnt_d = cnt_q;
      smp_d = smp_q;
      if (!en_i) begin
         cnt_d = '0;
      end else begin
         if (cnt_q == presc_i - 6'd1) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 6'd1;
         end
         if (cnt_q == half - 6'd1) smp_d[0] = rx_i;
         if (cnt_q == half)        smp_d[1] = rx_i;
         if (cnt_q == half + 6'd1) smp_d[2] = rx_i;
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         cnt_q <= '0;
         smp_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         smp_q <= smp_d;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with optional parity and stop-bit checking.
// Optional feature macro: UART_RX_START_GLITCH_EN (reject start bits that vote high).
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rest,
   input  logic                  rx_in,
   input  logic [5:0]            prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   rx_state_e             state_q, state_d;
   logic [5:0]            presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_bit_q, par_bit_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic smp_en, bit_end, smp_bit, start_frame, calc_perr;

   assign smp_en      = state_q inside {START, DATA, PARITY, STOP};
   assign start_frame = !rx_in && (state_q == IDLE || state_q == CHECK);
   assign calc_perr   = par_en_q && ((^shift_q ^ par_typ_q) != par_bit_q);

   uart_rx_sampler u_sampler (
      .clk       (clk),
      .rest      (rest),
      .en_i      (smp_en),
      .rx_i      (rx_in),
      .presc_i   (presc_q),
      .bit_end_o (bit_end),
      .bit_o     (smp_bit)
   );

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_bit_d    = par_bit_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = par_err_q;
      stp_err_d    = stp_err_q;

      case (state_q)
         IDLE: ;
         START: begin
            if (bit_end) begin
`ifdef UART_RX_START_GLITCH_EN
               state_d = smp_bit ? IDLE : DATA;
`else
               state_d = DATA;
`endif
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {smp_bit, shift_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_bit_d = smp_bit;
               state_d   = STOP;
            end
         end
         // Flags and data are loaded as CHECK is entered so they are visible during CHECK.
         STOP: begin
            if (bit_end) begin
               state_d   = CHECK;
               par_err_d = calc_perr;
               stp_err_d = !smp_bit;
               if (!calc_perr && smp_bit) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
            end
         end
         CHECK: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (start_frame) begin
         state_d   = START;
         presc_d   = legal_prescale(prescale);
         par_en_d  = par_en;
         par_typ_d = par_typ;
         bit_cnt_d = '0;
         par_err_d = 1'b0;
         stp_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q      <= IDLE;
         presc_q      <= PRESCALE_8;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_bit_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign p_data     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames
// compared against a frame-level reference model (expected words and error flags).
module tb_uart_rx_core;

   logic       clk = 1'b0;
   logic       rest;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   always #5 clk = ~clk;

   uart_rx_core #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rest       (rest),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: words that should appear on data_valid, and the
   // register values that should be held after the last frame.
   logic [7:0] expQ[$];
   logic [7:0] expPData;
   logic       expParErr;
   logic       expStpErr;

   // Monitor: capture every data_valid pulse and flag pulses wider than one clock.
   logic [7:0] dvQ[$];
   int         longPulse = 0;
   logic       prevDv = 1'b0;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dvQ.push_back(p_data);
         if (prevDv) longPulse++;
      end
      prevDv = (data_valid === 1'b1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int effPrescale(input logic [5:0] p);
      if (p == 6'd8 || p == 6'd16 || p == 6'd32) return int'(p);
      return 8;
   endfunction

   // Drives one complete frame on rx_in and updates the reference model.
   task automatic applyStimulus(input logic [7:0] data, input logic [5:0] pIn, input logic parEn,
                                input logic parTyp, input logic flipPar, input logic stopBit,
                                input logic mangle);
      logic bits[$];
      int   p;
      logic good;
      p        = effPrescale(pIn);
      prescale = pIn;
      par_en   = parEn;
      par_typ  = parTyp;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (parEn) bits.push_back(1'(($countones(data) % 2) ^ int'(parTyp) ^ int'(flipPar)));
      bits.push_back(stopBit);
      foreach (bits[i]) begin
         rx_in = bits[i];
         repeat (p) @(negedge clk);
         if (i == 0 && mangle) begin
            prescale = 6'($urandom);
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
         end
      end
      rx_in     = 1'b1;
      good      = stopBit && !(parEn && flipPar);
      expParErr = parEn && flipPar;
      expStpErr = !stopBit;
      if (good) begin
         expQ.push_back(data);
         expPData = data;
      end
   endtask

   task automatic verifyFrames(input string tag);
      checkOutput({tag, "_pulses"}, 32'(dvQ.size()), 32'(expQ.size()));
      while (dvQ.size() > 0 && expQ.size() > 0) begin
         checkOutput({tag, "_word"}, 32'(dvQ.pop_front()), 32'(expQ.pop_front()));
      end
      dvQ.delete();
      expQ.delete();
      checkOutput({tag, "_p_data"}, 32'(p_data), 32'(expPData));
      checkOutput({tag, "_par_err"}, 32'(par_err), 32'(expParErr));
      checkOutput({tag, "_stp_err"}, 32'(stp_err), 32'(expStpErr));
      checkOutput({tag, "_dv_idle"}, 32'(data_valid), 32'd0);
      checkOutput({tag, "_pulse_width"}, 32'(longPulse), 32'd0);
   endtask

   initial begin
      logic [7:0] abortData;
      logic [5:0] pSel;
      rest      = 1'b0;
      rx_in     = 1'b1;
      prescale  = 6'd8;
      par_en    = 1'b0;
      par_typ   = 1'b0;
      expPData  = 8'h00;
      expParErr = 1'b0;
      expStpErr = 1'b0;

      idle(3);
      checkOutput("reset_p_data", 32'(p_data), 32'd0);
      checkOutput("reset_dv", 32'(data_valid), 32'd0);
      checkOutput("reset_par_err", 32'(par_err), 32'd0);
      checkOutput("reset_stp_err", 32'(stp_err), 32'd0);
      rest = 1'b1;
      idle(10);
      verifyFrames("idle_after_reset");

      applyStimulus(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      verifyFrames("p8_parity_ok");

      applyStimulus(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      verifyFrames("p16_parity_bad");

      applyStimulus(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);
      verifyFrames("p32_stop_bad");

      applyStimulus(8'h5A, 6'd20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(4);
      verifyFrames("illegal_prescale");

      applyStimulus(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hAA, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      verifyFrames("back_to_back");

      for (int n = 0; n < 14; n++) begin
         case ($urandom_range(0, 3))
            0: pSel = 6'd8;
            1: pSel = 6'd16;
            2: pSel = 6'd32;
            default: pSel = 6'($urandom_range(0, 63));
         endcase
         applyStimulus(8'($urandom), pSel, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0), 1'($urandom));
         idle($urandom_range(4, 8));
         verifyFrames($sformatf("rand%0d", n));
      end

      // Three-clock low glitch on an idle line at 16 clocks per bit.
      prescale = 6'd16;
      par_en   = 1'b0;
      par_typ  = 1'b0;
      rx_in    = 1'b0;
      idle(3);
      rx_in = 1'b1;
`ifdef UART_RX_START_GLITCH_EN
      idle(40);
`else
      idle(16 * 10 + 6);
      expQ.push_back(8'hFF);
      expPData  = 8'hFF;
      expParErr = 1'b0;
      expStpErr = 1'b0;
`endif
      verifyFrames("start_glitch");

      // Reset in the middle of data bit 4 of a frame.
      abortData = 8'hC3;
      prescale  = 6'd8;
      par_en    = 1'b0;
      rx_in     = 1'b0;
      idle(8);
      for (int i = 0; i < 4; i++) begin
         rx_in = abortData[i];
         idle(8);
      end
      rx_in = abortData[4];
      idle(4);
      rest = 1'b0;
      #1;
      checkOutput("midreset_p_data", 32'(p_data), 32'd0);
      checkOutput("midreset_dv", 32'(data_valid), 32'd0);
      checkOutput("midreset_par_err", 32'(par_err), 32'd0);
      checkOutput("midreset_stp_err", 32'(stp_err), 32'd0);
      expPData  = 8'h00;
      expParErr = 1'b0;
      expStpErr = 1'b0;
      idle(3);
      rx_in = 1'b1;
      rest  = 1'b1;
      idle(40);
      verifyFrames("after_midreset");

      applyStimulus(8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      verifyFrames("clean_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
